// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: command-driven 8-bit LFSR burst sequencer; optional step counter via LFSR_BURST_CTRL_STEPCNT_EN
module lfsr_burst_ctrl #(
    parameter logic [7:0] DEFAULT_SEED = 8'h8A,
    parameter int          LEN_W        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [7:0]  cmd_arg,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
`ifdef LFSR_BURST_CTRL_STEPCNT_EN
    ,
    output logic [15:0] step_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [7:0]     s_q, s_d, s_next;
    logic [LEN_W:0] rem_q, rem_d;
    logic [LEN_W-1:0] len;
    logic           hs, last, load;

    assign s_next = {s_q[6:0], s_q[0] ^ s_q[3] ^ s_q[5] ^ s_q[6]};
    assign len    = cmd_arg[LEN_W-1:0];
    assign hs     = (state_q == RUN) && out_ready;
    assign last   = rem_q == (LEN_W+1)'(1);
    assign load   = (state_q == IDLE) && cmd_valid && !cmd_op;

    // Every output decodes from flops only, so nothing combinational reaches them from inputs
    assign cmd_ready = state_q == IDLE;
    assign out_valid = state_q == RUN;
    assign out_data  = s_q;
    assign out_last  = (state_q == RUN) && last;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;

    // Next-state: command decode in IDLE, beat stepping and abort in RUN, single DONE cycle
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_op) begin
                    rem_d   = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
                    state_d = RUN;
                end else if (cmd_valid) begin
                    s_d = (cmd_arg == 8'h00) ? DEFAULT_SEED : cmd_arg;
                end
            end
            RUN: begin
                if (hs) begin
                    s_d   = s_next;
                    rem_d = rem_q - 1'b1;
                end
                if (hs && last) begin
                    state_d = DONE;
                end else if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, LFSR and remaining-beat registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= DEFAULT_SEED;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            rem_q   <= rem_d;
        end
    end

`ifdef LFSR_BURST_CTRL_STEPCNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Steps since reset or LOAD, saturating
    always_comb begin
        cnt_d = load ? 16'd0 : (hs && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    // Step counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_cnt = cnt_q;
`else
    logic unused_load;
    assign unused_load = load;
`endif
endmodule
